// File: rtl/data_request_server_pkg.sv
// Shared request/response types for the thread data interface and the
// queue-entry layout used by the data request server.
package DataInterface_pkg;

  typedef struct packed {
    logic        valid;
    logic [7:0]  id;
    logic [15:0] address;
  } read_request_t;

  typedef struct packed {
    logic        valid;
    logic [15:0] address;
    logic [63:0] data;
  } write_request_t;

  typedef struct packed {
    logic        valid;
    logic [7:0]  id;
    logic [15:0] address;
    logic [63:0] data;
    logic        error;
  } read_response_t;

  typedef struct packed {
    logic        is_write;
    logic [7:0]  id;
    logic [15:0] address;
    logic [63:0] data;
  } dreq_entry_t;

  // True when a 16-bit request address falls inside a store of 'words' entries.
  function automatic logic addr_in_range(input logic [15:0] addr, input int unsigned words);
    return ({16'd0, addr} < 32'(words));
  endfunction

endpackage

// File: rtl/data_request_server_request_fifo3.sv
// Circular request queue: up to three pushes and one pop per cycle.
// The pop is self-generated: the head is consumed whenever the queue is non-empty.
module request_fifo3
  import DataInterface_pkg::*;
#(
  parameter int QDEPTH = 8,
  localparam int PW = $clog2(QDEPTH),
  localparam int CW = $clog2(QDEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        push_cnt,
  input  dreq_entry_t [2:0] push_entries,
  output logic [CW-1:0]     count,
  output dreq_entry_t       head,
  output logic              pop
);

  dreq_entry_t   mem_q [QDEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] slot_ptr_s [3];

  // Pointer advance by 0..3 with wrap at QDEPTH (need not be a power of two).
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] k);
    logic [PW+1:0] s;
    s = {2'b00, p} + {{PW{1'b0}}, k};
    if (s >= (PW+2)'(QDEPTH)) begin
      s = s - (PW+2)'(QDEPTH);
    end else begin
      s = s;
    end
    return s[PW-1:0];
  endfunction

  // Next-state for pointers and occupancy, plus the write slot of each pushed entry.
  always_comb begin
    pop     = (count_q != {CW{1'b0}});
    head    = mem_q[head_q];
    head_d  = pop ? ptr_add(head_q, 2'd1) : head_q;
    tail_d  = ptr_add(tail_q, push_cnt);
    count_d = count_q + CW'(push_cnt) - CW'(pop);
    count   = count_q;
    for (int i = 0; i < 3; i++) begin
      slot_ptr_s[i] = ptr_add(tail_q, 2'(i));
    end
  end

  // Pointer and occupancy registers; reset empties the queue.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= {PW{1'b0}};
      tail_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage: write the first push_cnt compacted entries at the tail.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst && (2'(i) < push_cnt)) begin
        mem_q[slot_ptr_s[i]] <= push_entries[i];
      end
    end
  end

endmodule

// File: rtl/data_request_server.sv
// Memory-side responder: queues write/read1/read2 bundles in that order,
// services one access per cycle against a 64-bit word store and returns
// read data on a single tagged response port.
module data_request_server
  import DataInterface_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int QDEPTH    = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  read_request_t  read1,
  input  read_request_t  read2,
  input  write_request_t write,
  output read_response_t response,
  output logic           stall,
  output logic [15:0]    drop_count
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  dreq_entry_t       w_entry_s, r1_entry_s, r2_entry_s;
  dreq_entry_t [2:0] push_entries_s;
  logic [1:0]        n_s;
  logic [1:0]        push_cnt_s;
  logic [CW-1:0]     count_s;
  logic [CW-1:0]     free_s;
  logic              accept_s;
  logic              drop_s;
  dreq_entry_t       head_s;
  logic              pop_s;
  logic              head_in_range_s;
  logic [AW-1:0]     head_idx_s;
  read_response_t    response_d, response_q;
  logic [15:0]       drop_count_d, drop_count_q;
  logic [63:0]       mem_q [MEM_WORDS];

  // Bundle compaction (write, read1, read2 order) and the all-or-nothing accept decision.
  always_comb begin
    w_entry_s  = '{is_write: 1'b1, id: 8'd0, address: write.address, data: write.data};
    r1_entry_s = '{is_write: 1'b0, id: read1.id, address: read1.address, data: 64'd0};
    r2_entry_s = '{is_write: 1'b0, id: read2.id, address: read2.address, data: 64'd0};
    n_s = 2'(write.valid) + 2'(read1.valid) + 2'(read2.valid);
    push_entries_s[0] = write.valid ? w_entry_s : (read1.valid ? r1_entry_s : r2_entry_s);
    push_entries_s[1] = (write.valid && read1.valid) ? r1_entry_s : r2_entry_s;
    push_entries_s[2] = r2_entry_s;
    // Only registered occupancy is credited; a same-cycle pop does not make room.
    free_s     = CW'(QDEPTH) - count_s;
    accept_s   = (32'(n_s) <= 32'(free_s));
    push_cnt_s = (rst && accept_s) ? n_s : 2'd0;
    drop_s     = rst && (n_s != 2'd0) && !accept_s;
    stall      = (32'(free_s) < 32'd3);
  end

  request_fifo3 #(
    .QDEPTH(QDEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_cnt     (push_cnt_s),
    .push_entries (push_entries_s),
    .count        (count_s),
    .head         (head_s),
    .pop          (pop_s)
  );

  // Head decode and next response: reads latch store data, out-of-range reads flag error.
  always_comb begin
    head_in_range_s = addr_in_range(head_s.address, 32'(MEM_WORDS));
    head_idx_s      = head_s.address[AW-1:0];
    response_d      = '0;
    if (pop_s && !head_s.is_write) begin
      response_d.valid   = 1'b1;
      response_d.id      = head_s.id;
      response_d.address = head_s.address;
      response_d.data    = head_in_range_s ? mem_q[head_idx_s] : 64'd0;
      response_d.error   = !head_in_range_s;
    end else begin
      response_d = '0;
    end
    drop_count_d = (drop_s && (drop_count_q != 16'hFFFF)) ? (drop_count_q + 16'd1) : drop_count_q;
  end

  // Word store update from a serviced in-range write; contents are not reset.
  always_ff @(posedge clk) begin
    if (rst && pop_s && head_s.is_write && head_in_range_s) begin
      mem_q[head_idx_s] <= head_s.data;
    end
  end

  // Response register and saturating drop counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      response_q   <= '0;
      drop_count_q <= 16'd0;
    end else begin
      response_q   <= response_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign response   = response_q;
  assign drop_count = drop_count_q;

endmodule
